ins_mem_loader: RTL and testbench

INS_MEM_LOADER -- requirements
Module: ins_mem_loader

---
 rtl/ins_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_ins_mem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: streams host bytes into instruction memory as
// big-endian 32-bit words while holding the CPU in reset.
//
// Ports:
//   CLK, RST        clock, async active-low reset
//   LoadReq         start a session (IDLE only); WordCount sampled then
//   Abort           drop current session, back to IDLE
//   ByteIn/Valid    host byte stream; ByteReady is the accept strobe
//   InsMemRW        1 = read, 0 = write (single WRITE cycle per word)
//   IAddr, DataOut  instruction memory byte address and write data
//   Busy, Done      session active / one-cycle completion pulse
//   CPURstN         active-low CPU hold, released on completion
module ins_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LoadReq,
  input  logic [7:0]  WordCount,
  input  logic        Abort,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        InsMemRW,
  output logic [31:0] IAddr,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        Done,
  output logic        CPURstN
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] MAX_W8 =
    (MAX_WORDS > 255) ? 8'd255 : 8'(MAX_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  idx_q;
  logic [1:0]  bi_q;
  logic [31:0] asm_q;
  logic [31:0] dout_q;
  logic        rstn_q;

  logic [7:0]  cnt_load;
  logic [8:0]  idx_nxt;
  logic        start;
  logic        xfer;
  logic        wr_en;

  assign cnt_load = ({24'd0, WordCount} > MAX_WORDS) ? MAX_W8 : WordCount;
  assign idx_nxt  = {1'b0, idx_q} + 9'd1;
  assign start    = (state_q == S_IDLE) && LoadReq;
  assign xfer     = ByteReady && ByteValid;
  assign wr_en    = (state_q == S_WRITE) && !Abort;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (LoadReq) begin
          state_d = (cnt_load == 8'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (xfer && bi_q == 2'd3) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (idx_nxt == {1'b0, cnt_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ByteReady = 1'b0;
    InsMemRW  = 1'b1;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        ByteReady = !Abort;
        Busy      = 1'b1;
      end
      S_WRITE: begin
        InsMemRW = Abort;
        Busy     = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign IAddr   = BASE_ADDR + {22'd0, idx_q, 2'b00};
  assign DataOut = dout_q;
  assign CPURstN = rstn_q;

  // asm_q shifts bytes in so the first byte lands in [31:24];
  // dout_q only changes on a completed word, so a partial word
  // is never presented to memory.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= 8'd0;
      idx_q  <= 8'd0;
      bi_q   <= 2'd0;
      asm_q  <= 32'd0;
      dout_q <= 32'd0;
      rstn_q <= 1'b0;
    end else begin
      if (start) begin
        cnt_q  <= cnt_load;
        idx_q  <= 8'd0;
        bi_q   <= 2'd0;
        rstn_q <= 1'b0;
      end
      if (xfer) begin
        asm_q <= {asm_q[23:0], ByteIn};
        bi_q  <= bi_q + 2'd1;
        if (bi_q == 2'd3) begin
          dout_q <= {asm_q[23:0], ByteIn};
        end
      end
      if (wr_en) begin
        idx_q <= idx_nxt[7:0];
      end
      if (state_d == S_DONE) begin
        rstn_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: randomized sessions against a queue-based
// model of expected memory writes, plus directed corner cases.
module tb_ins_mem_loader;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int MAXW = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LoadReq = 1'b0;
  logic [7:0]  WordCount = 8'd0;
  logic        Abort = 1'b0;
  logic [7:0]  ByteIn = 8'd0;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        InsMemRW;
  logic [31:0] IAddr;
  logic [31:0] DataOut;
  logic        Busy;
  logic        Done;
  logic        CPURstN;

  ins_mem_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .LoadReq(LoadReq),
    .WordCount(WordCount),
    .Abort(Abort),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .InsMemRW(InsMemRW),
    .IAddr(IAddr),
    .DataOut(DataOut),
    .Busy(Busy),
    .Done(Done),
    .CPURstN(CPURstN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  int cyc_n = 0;
  always @(posedge CLK) cyc_n++;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (!InsMemRW) begin
        wa_q.push_back(IAddr);
        wd_q.push_back(DataOut);
        wc_q.push_back(cyc_n);
      end
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  logic [7:0] fixed_b[8] = '{8'h20, 8'h01, 8'h00, 8'h05,
                             8'h8C, 8'h02, 8'h00, 8'h04};

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random
  // abort_at: byte count after which Abort is raised, <0 none
  task automatic run(input string tag, input int wc,
                     input int gap_mode, input int abort_at,
                     input bit use_fixed);
    logic [7:0] bytes[$];
    int         exp_cyc[$];
    int         eff;
    int         nbytes;
    int         sent;
    int         cyc;
    int         nw;
    int         wait_n;
    bit         aborting;
    logic [31:0] w;
    eff = (wc > MAXW) ? MAXW : wc;
    nbytes = 4 * eff;
    aborting = (abort_at >= 0);
    for (int i = 0; i < nbytes; i++) begin
      bytes.push_back(use_fixed ? fixed_b[i % 8] : 8'($urandom));
    end
    clear_mon();
    LoadReq = 1'b1;
    WordCount = 8'(wc);
    step();
    LoadReq = 1'b0;
    WordCount = 8'($urandom);
    if (eff == 0) begin
      @(negedge CLK);
      check({tag, "_done_next"}, Done, 1);
      step();
    end
    sent = 0;
    cyc = 0;
    while (sent < nbytes && !(aborting && sent == abort_at)
           && cyc < 5000) begin
      unique case (gap_mode)
        0: ByteValid = 1'b1;
        1: ByteValid = cyc[0];
        default: ByteValid = ($urandom_range(99) >= 40);
      endcase
      ByteIn = ByteValid ? bytes[sent] : 8'($urandom);
      // randomly tickle LoadReq, which must be ignored mid-session
      LoadReq = ($urandom_range(15) == 0);
      WordCount = 8'($urandom);
      @(negedge CLK);
      if (ByteValid && ByteReady) begin
        sent++;
        if (sent % 4 == 0) exp_cyc.push_back(cyc_n + 1);
      end
      step();
      cyc++;
    end
    LoadReq = 1'b0;
    check({tag, "_feed_timeout"}, (cyc >= 5000), 0);
    if (aborting) begin
      Abort = 1'b1;
      ByteValid = 1'b1;
      ByteIn = 8'($urandom);
      @(negedge CLK);
      check({tag, "_abort_ready"}, ByteReady, 0);
      check({tag, "_abort_nowr"}, InsMemRW, 1);
      step();
      Abort = 1'b0;
      ByteValid = 1'b0;
      repeat (3) step();
      nw = abort_at / 4;
      if (abort_at > 0 && abort_at % 4 == 0) nw--;
    end else begin
      ByteValid = 1'b0;
      wait_n = 0;
      while (done_cnt == 0 && wait_n < 50) begin
        step();
        wait_n++;
      end
      check({tag, "_done_timeout"}, (wait_n >= 50), 0);
      repeat (3) step();
      nw = eff;
    end
    @(negedge CLK);
    check({tag, "_nwrites"}, wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
      check({tag, "_addr"}, wa_q[i], BASE + 32'(4 * i));
      check({tag, "_data"}, wd_q[i], w);
      if (i < exp_cyc.size() && i < wc_q.size())
        check({tag, "_wcyc"}, wc_q[i], exp_cyc[i]);
    end
    check({tag, "_donecnt"}, done_cnt, aborting ? 0 : 1);
    check({tag, "_cpurst"}, CPURstN, aborting ? 0 : 1);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_iaddr"}, IAddr, BASE + 32'(4 * nw));
    if (eff == 0) check({tag, "_busy_never"}, busy_cnt, 0);
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, ByteReady, 0);
    check({tag, "_rw"}, InsMemRW, 1);
    check({tag, "_iaddr"}, IAddr, BASE);
    check({tag, "_dout"}, DataOut, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_cpurst"}, CPURstN, 0);
  endtask

  initial begin
    int wc;
    int nb;
    int ab;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("rst");
    step();
    RST = 1'b1;
    step();
    @(negedge CLK);
    check_reset_vals("post_rst");
    step();

    run("two_words", 2, 0, -1, 1'b1);
    run("gapped", 1, 1, -1, 1'b0);
    run("zero", 0, 0, -1, 1'b0);
    run("abort6", 3, 0, 6, 1'b0);
    run("restart", 2, 2, -1, 1'b0);
    run("abort_wr", 3, 0, 8, 1'b0);
    run("clamp", 200, 0, -1, 1'b0);

    // Abort while idle must do nothing
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    @(negedge CLK);
    check("idle_abort_cpurst", CPURstN, 1);
    step();

    // Reset mid-word, with an ignored LoadReq in COLLECT before it
    clear_mon();
    LoadReq = 1'b1;
    WordCount = 8'd2;
    step();
    LoadReq = 1'b0;
    ByteValid = 1'b1;
    ByteIn = 8'hA5;
    repeat (2) step();
    LoadReq = 1'b1;
    WordCount = 8'd0;
    step();
    LoadReq = 1'b0;
    @(negedge CLK);
    check("midreq_busy", Busy, 1);
    check("midreq_done", done_cnt, 0);
    #2;
    RST = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) step();
    RST = 1'b1;
    clear_mon();
    repeat (12) step();
    ByteValid = 1'b0;
    @(negedge CLK);
    check("post_rst_nwrites", wa_q.size(), 0);
    check("post_rst_busy", busy_cnt, 0);
    step();

    for (int s = 0; s < 24; s++) begin
      wc = ($urandom_range(7) == 0) ? int'($urandom_range(255, 65))
                                    : int'($urandom_range(12));
      nb = 4 * ((wc > MAXW) ? MAXW : wc);
      ab = -1;
      if (nb > 0 && $urandom_range(2) == 0) ab = int'($urandom_range(nb - 1));
      run("rand", wc, int'($urandom_range(2)), ab, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
